// File: rtl/rheed_pkg.sv
// Shared types and constants for the RHEED frame front-end: FSM state encoding,
// beat geometry and the crop-origin clamp.
package rheed_pkg;

  localparam int unsigned PixelsPerBeatDef = 32;
  localparam int unsigned BeatWidth        = 256;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StRun,
    StWaitRes
  } state_e;

  // Clamp a requested origin so the crop window stays inside the frame.
  function automatic int unsigned crop_clamp(input int unsigned req,
                                             input int unsigned max_origin);
    return (req > max_origin) ? max_origin : req;
  endfunction

endpackage

// File: rtl/rheed_wait_timer.sv
// Loadable down-counter with an expiry flag; expired_o is high while the count is zero.
module rheed_wait_timer #(
  parameter int unsigned Width = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             expired_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/rheed_frame_scheduler.sv
// Frame admission controller: admits one camera frame at a time into the inference
// pipeline, sinks frames that arrive while one is in flight, and tracks results.
module rheed_frame_scheduler
  import rheed_pkg::*;
#(
  parameter int unsigned IN_ROWS           = 20,
  parameter int unsigned IN_COLS           = 20,
  parameter int unsigned OUT_ROWS          = 20,
  parameter int unsigned OUT_COLS          = 20,
  parameter int unsigned PIXELS_PER_BEAT   = PixelsPerBeatDef,
  parameter int unsigned RESULTS_PER_FRAME = 1,
  parameter int unsigned TIMEOUT_CYCLES    = 1048576
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [$clog2(IN_COLS)-1:0] cfg_crop_x0,
  input  logic [$clog2(IN_ROWS)-1:0] cfg_crop_y0,
  input  logic                       cam_tvalid,
  output logic                       cam_tready,
  input  logic [BeatWidth-1:0]       cam_tdata,
  input  logic                       cam_tuser,
  output logic                       pipe_tvalid,
  input  logic                       pipe_tready,
  output logic [BeatWidth-1:0]       pipe_tdata,
  output logic                       ap_start,
  output logic [$clog2(IN_COLS)-1:0] crop_x0,
  output logic [$clog2(IN_ROWS)-1:0] crop_y0,
  input  logic                       res_tvalid,
  input  logic                       res_tready,
  output logic                       busy,
  output logic [31:0]                frames_started,
  output logic [31:0]                frames_dropped,
  output logic [31:0]                results_seen,
  output logic                       frame_err,
  output logic                       timeout_err
);

  localparam int unsigned XW       = $clog2(IN_COLS);
  localparam int unsigned YW       = $clog2(IN_ROWS);
  localparam int unsigned Beats    = IN_ROWS * IN_COLS / PIXELS_PER_BEAT;
  localparam int unsigned BeatCntW = $clog2(Beats + 1);
  localparam int unsigned ResCntW  = $clog2(RESULTS_PER_FRAME + 1);
  localparam int unsigned TmrW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [BeatCntW-1:0] LastBeat = BeatCntW'(Beats - 1);
  localparam logic [ResCntW-1:0]  LastRes  = ResCntW'(RESULTS_PER_FRAME - 1);
  localparam logic [TmrW-1:0]     TmrLoad  = TmrW'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [BeatCntW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [ResCntW-1:0]    res_cnt_q, res_cnt_d;
  logic [XW-1:0]         crop_x0_q, crop_x0_d;
  logic [YW-1:0]         crop_y0_q, crop_y0_d;
  logic [31:0]           started_q, started_d;
  logic [31:0]           dropped_q, dropped_d;
  logic [31:0]           results_q, results_d;
  logic                  frame_err_q, frame_err_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  tmr_load, tmr_en, tmr_expired;
  logic                  sof_valid, res_hs;

  assign sof_valid = cam_tvalid & cam_tuser;
  assign res_hs    = res_tvalid & res_tready;

  rheed_wait_timer #(
    .Width (TmrW)
  ) u_wait_timer (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (tmr_load),
    .load_val_i (TmrLoad),
    .en_i       (tmr_en),
    .expired_o  (tmr_expired)
  );

  always_comb begin
    state_d       = state_q;
    cam_tready    = 1'b1;
    pipe_tvalid   = 1'b0;
    beat_cnt_d    = beat_cnt_q;
    res_cnt_d     = res_cnt_q;
    crop_x0_d     = crop_x0_q;
    crop_y0_d     = crop_y0_q;
    started_d     = started_q;
    dropped_d     = dropped_q;
    results_d     = res_hs ? results_q + 32'd1 : results_q;
    frame_err_d   = frame_err_q;
    timeout_err_d = timeout_err_q;
    tmr_load      = 1'b0;
    tmr_en        = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Hold the SOF beat so it is the first beat the pipeline sees.
        if (sof_valid && enable) begin
          cam_tready = 1'b0;
          state_d    = StStart;
        end
      end

      StStart: begin
        cam_tready = 1'b0;
        crop_x0_d  = XW'(crop_clamp(32'(cfg_crop_x0), IN_COLS - OUT_COLS));
        crop_y0_d  = YW'(crop_clamp(32'(cfg_crop_y0), IN_ROWS - OUT_ROWS));
        started_d  = started_q + 32'd1;
        beat_cnt_d = '0;
        state_d    = StRun;
      end

      StRun: begin
        pipe_tvalid = cam_tvalid;
        cam_tready  = pipe_tready;
        if (cam_tvalid && pipe_tready) begin
          beat_cnt_d = beat_cnt_q + BeatCntW'(1);
          if (cam_tuser && (beat_cnt_q != '0)) begin
            frame_err_d = 1'b1;
          end
          if (beat_cnt_q == LastBeat) begin
            res_cnt_d = '0;
            tmr_load  = 1'b1;
            state_d   = StWaitRes;
          end
        end
      end

      StWaitRes: begin
        tmr_en = 1'b1;
        if (sof_valid) begin
          dropped_d = dropped_q + 32'd1;
        end
        if (res_hs) begin
          res_cnt_d = res_cnt_q + ResCntW'(1);
          if (res_cnt_q == LastRes) begin
            state_d = StIdle;
          end
        end
        // Completion in the same cycle as expiry takes priority.
        if ((state_d != StIdle) && tmr_expired) begin
          timeout_err_d = 1'b1;
          state_d       = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      beat_cnt_q    <= '0;
      res_cnt_q     <= '0;
      crop_x0_q     <= '0;
      crop_y0_q     <= '0;
      started_q     <= '0;
      dropped_q     <= '0;
      results_q     <= '0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      res_cnt_q     <= res_cnt_d;
      crop_x0_q     <= crop_x0_d;
      crop_y0_q     <= crop_y0_d;
      started_q     <= started_d;
      dropped_q     <= dropped_d;
      results_q     <= results_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign pipe_tdata     = cam_tdata;
  assign ap_start       = (state_q == StStart);
  assign busy           = (state_q != StIdle);
  assign crop_x0        = crop_x0_q;
  assign crop_y0        = crop_y0_q;
  assign frames_started = started_q;
  assign frames_dropped = dropped_q;
  assign results_seen   = results_q;
  assign frame_err      = frame_err_q;
  assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_rheed_frame_scheduler.sv
// Bench for rheed_frame_scheduler: a cycle-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_rheed_frame_scheduler;

  localparam int unsigned InRows = 16;
  localparam int unsigned InCols = 16;
  localparam int unsigned OutRows = 8;
  localparam int unsigned OutCols = 8;
  localparam int unsigned Ppb = 32;
  localparam int unsigned Rpf = 1;
  localparam int unsigned To = 16;
  localparam int unsigned Beats = InRows * InCols / Ppb;
  localparam int unsigned MaxX = InCols - OutCols;
  localparam int unsigned MaxY = InRows - OutRows;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [3:0]   cfg_crop_x0, cfg_crop_y0, crop_x0, crop_y0;
  logic         cam_tvalid, cam_tready, cam_tuser;
  logic [255:0] cam_tdata, pipe_tdata;
  logic         pipe_tvalid, pipe_tready;
  logic         ap_start, res_tvalid, res_tready, busy;
  logic [31:0]  frames_started, frames_dropped, results_seen;
  logic         frame_err, timeout_err;

  int errors = 0;
  int checks = 0;

  rheed_frame_scheduler #(
    .IN_ROWS           (InRows),
    .IN_COLS           (InCols),
    .OUT_ROWS          (OutRows),
    .OUT_COLS          (OutCols),
    .PIXELS_PER_BEAT   (Ppb),
    .RESULTS_PER_FRAME (Rpf),
    .TIMEOUT_CYCLES    (To)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .cfg_crop_x0    (cfg_crop_x0),
    .cfg_crop_y0    (cfg_crop_y0),
    .cam_tvalid     (cam_tvalid),
    .cam_tready     (cam_tready),
    .cam_tdata      (cam_tdata),
    .cam_tuser      (cam_tuser),
    .pipe_tvalid    (pipe_tvalid),
    .pipe_tready    (pipe_tready),
    .pipe_tdata     (pipe_tdata),
    .ap_start       (ap_start),
    .crop_x0        (crop_x0),
    .crop_y0        (crop_y0),
    .res_tvalid     (res_tvalid),
    .res_tready     (res_tready),
    .busy           (busy),
    .frames_started (frames_started),
    .frames_dropped (frames_dropped),
    .results_seen   (results_seen),
    .frame_err      (frame_err),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 start pulse, 2 forwarding, 3 awaiting results.
  int unsigned m_phase, m_beats, m_wait, m_res;
  logic [3:0]  m_cx, m_cy;
  logic [31:0] m_started, m_dropped, m_results;
  logic        m_ferr, m_terr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0; m_beats <= 0; m_wait <= 0; m_res <= 0;
      m_cx <= '0; m_cy <= '0;
      m_started <= '0; m_dropped <= '0; m_results <= '0;
      m_ferr <= 1'b0; m_terr <= 1'b0;
    end else begin
      if (res_tvalid && res_tready) m_results <= m_results + 1;
      case (m_phase)
        0: if (cam_tvalid && cam_tuser && enable) m_phase <= 1;
        1: begin
          m_cx      <= (cfg_crop_x0 > MaxX) ? 4'(MaxX) : cfg_crop_x0;
          m_cy      <= (cfg_crop_y0 > MaxY) ? 4'(MaxY) : cfg_crop_y0;
          m_started <= m_started + 1;
          m_beats   <= 0;
          m_phase   <= 2;
        end
        2: if (cam_tvalid && pipe_tready) begin
          if (cam_tuser && m_beats != 0) m_ferr <= 1'b1;
          m_beats <= m_beats + 1;
          if (m_beats + 1 == Beats) begin
            m_phase <= 3; m_wait <= 0; m_res <= 0;
          end
        end
        3: begin
          if (cam_tvalid && cam_tuser) m_dropped <= m_dropped + 1;
          if (res_tvalid && res_tready && m_res + 1 == Rpf) begin
            m_phase <= 0;
          end else begin
            if (res_tvalid && res_tready) m_res <= m_res + 1;
            if (m_wait == To - 1) begin
              m_terr  <= 1'b1;
              m_phase <= 0;
            end else begin
              m_wait <= m_wait + 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  int unsigned ap_cnt = 0;
  int unsigned fwd_cnt = 0;

  always @(negedge clk) begin : cmp
    logic exp_tready;
    exp_tready = (m_phase == 0) ? !(cam_tvalid && cam_tuser && enable) :
                 (m_phase == 1) ? 1'b0 :
                 (m_phase == 2) ? pipe_tready : 1'b1;
    check("cam_tready", cam_tready, exp_tready);
    check("pipe_tvalid", pipe_tvalid, (m_phase == 2) && cam_tvalid);
    check("pipe_tdata", pipe_tdata, cam_tdata);
    check("ap_start", ap_start, m_phase == 1);
    check("busy", busy, m_phase != 0);
    check("crop_x0", crop_x0, m_cx);
    check("crop_y0", crop_y0, m_cy);
    check("frames_started", frames_started, m_started);
    check("frames_dropped", frames_dropped, m_dropped);
    check("results_seen", results_seen, m_results);
    check("frame_err", frame_err, m_ferr);
    check("timeout_err", timeout_err, m_terr);
    if (ap_start) ap_cnt++;
    if (pipe_tvalid && pipe_tready) fwd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat until it is accepted; stall = cycles spent waiting for cam_tready.
  task automatic send_beat(input logic sof, input logic [255:0] d, output int stall);
    bit hs;
    hs = 0;
    stall = 0;
    cam_tvalid = 1'b1; cam_tuser = sof; cam_tdata = d;
    for (int n = 0; n < 20 && !hs; n++) begin
      @(negedge clk);
      hs = cam_tready;
      tick();
      if (!hs) stall++;
    end
    if (!hs) begin
      checks++; errors++;
      $display("FAIL beat_accept: beat not accepted within 20 cycles at %0t", $time);
    end
    cam_tvalid = 1'b0; cam_tuser = 1'b0;
  endtask

  task automatic send_frame(input int err_beat, output int sof_stall);
    int s;
    sof_stall = 0;
    for (int i = 0; i < int'(Beats); i++) begin
      send_beat(i == 0 || i == err_beat, {8{32'hC0DE_0000 + 32'(i)}}, s);
      if (i == 0) sof_stall = s;
    end
  endtask

  task automatic give_result();
    res_tvalid = 1'b1; res_tready = 1'b1;
    tick();
    res_tvalid = 1'b0; res_tready = 1'b0;
  endtask

  initial begin
    int s, hsn, c, cyc;
    int unsigned ap0, fwd0;
    bit hs;
    reset = 1'b1; enable = 1'b0; cfg_crop_x0 = 4'd3; cfg_crop_y0 = 4'd4;
    cam_tvalid = 1'b0; cam_tuser = 1'b0; cam_tdata = '0;
    pipe_tready = 1'b1; res_tvalid = 1'b0; res_tready = 1'b0;
    repeat (3) tick();
    check("reset_busy", busy, 1'b0);
    check("reset_cam_tready", cam_tready, 1'b1);
    reset = 1'b0;
    tick();

    // SOF with enable low is sunk and not counted as dropped.
    send_beat(1'b1, {8{32'h5151_5151}}, s);
    check("disabled_sof_stall", 32'(s), 32'd0);
    check("disabled_sof_dropped", frames_dropped, 32'd0);
    check("disabled_sof_busy", busy, 1'b0);

    // Frame 1: crop (3,4), full throughput.
    enable = 1'b1;
    ap0 = ap_cnt; fwd0 = fwd_cnt;
    send_frame(-1, s);
    check("f1_sof_stall", 32'(s), 32'd2);
    check("f1_ap_pulses", 32'(ap_cnt - ap0), 32'd1);
    check("f1_fwd_beats", 32'(fwd_cnt - fwd0), 32'd8);
    check("f1_busy_wait", busy, 1'b1);
    give_result();
    check("f1_busy_after_res", busy, 1'b0);
    check("f1_started", frames_started, 32'd1);
    check("f1_results", results_seen, 32'd1);
    check("f1_crop_x", crop_x0, 4'd3);
    check("f1_crop_y", crop_y0, 4'd4);

    // Frame 2: clamp, then a second frame arrives while waiting and is dropped.
    cfg_crop_x0 = 4'd15; cfg_crop_y0 = 4'd15;
    send_frame(-1, s);
    fwd0 = fwd_cnt;
    send_frame(-1, s);
    check("drop_sof_stall", 32'(s), 32'd0);
    check("drop_fwd_beats", 32'(fwd_cnt - fwd0), 32'd0);
    check("drop_count", frames_dropped, 32'd1);
    check("f2_crop_x", crop_x0, 4'd8);
    check("f2_crop_y", crop_y0, 4'd8);
    give_result();
    check("f2_results", results_seen, 32'd2);

    // Frame 3: pipe_tready toggles during the frame.
    fwd0 = fwd_cnt; hsn = 0; c = 0;
    while (hsn < int'(Beats) && c < 80) begin
      pipe_tready = (c % 2 == 0);
      cam_tvalid = 1'b1; cam_tuser = (hsn == 0); cam_tdata = {8{32'hB000_0000 + 32'(hsn)}};
      @(negedge clk);
      hs = cam_tready;
      tick();
      if (hs) hsn++;
      c++;
    end
    check("bp_handshakes", 32'(hsn), 32'd8);
    check("bp_fwd_beats", 32'(fwd_cnt - fwd0), 32'd8);
    // First cycle after the 8th handshake: already sinking regardless of pipe_tready.
    cam_tuser = 1'b0; pipe_tready = 1'b0;
    @(negedge clk);
    check("bp_wait_tready", cam_tready, 1'b1);
    check("bp_wait_pvalid", pipe_tvalid, 1'b0);
    tick();
    cam_tvalid = 1'b0; pipe_tready = 1'b1;
    // Result in the same cycle the wait budget runs out: completion wins.
    repeat (14) tick();
    give_result();
    check("race_timeout_err", timeout_err, 1'b0);
    check("race_busy", busy, 1'b0);
    check("f3_results", results_seen, 32'd3);

    // Frame 4: no result, timeout 16 cycles after entering the wait.
    send_frame(-1, s);
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      if (timeout_err) break;
      tick();
      cyc++;
    end
    check("timeout_cycles", 32'(cyc), 32'd16);
    check("timeout_busy", busy, 1'b0);

    // Frame 5: admitted normally after timeout; stray SOF on beat 3.
    tick();
    send_frame(3, s);
    check("f5_sof_stall", 32'(s), 32'd2);
    check("f5_frame_err", frame_err, 1'b1);
    check("f5_started", frames_started, 32'd5);
    give_result();

    // Frame 6: asynchronous reset while forwarding.
    send_beat(1'b1, {8{32'hD000_0000}}, s);
    send_beat(1'b0, {8{32'hD000_0001}}, s);
    cam_tvalid = 1'b1; cam_tuser = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_ap_start", ap_start, 1'b0);
    check("arst_cam_tready", cam_tready, 1'b1);
    check("arst_pipe_tvalid", pipe_tvalid, 1'b0);
    check("arst_started", frames_started, 32'd0);
    check("arst_results", results_seen, 32'd0);
    check("arst_frame_err", frame_err, 1'b0);
    check("arst_timeout_err", timeout_err, 1'b0);
    check("arst_crop_x", crop_x0, 4'd0);
    cam_tvalid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
